// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: two requesters share one UART transmit serializer.
// Requesters are arbitrated round-robin, one byte is latched per grant, and
// an 8N1 frame (start, 8 data bits LSB-first, stop) is shifted out. The bit
// timing comes from an internal baud divider.
module uart_tx_scheduler #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic       tx_clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx,
    output logic       busy,
    output logic       active_src,
    output logic       uart_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_reg_q, shift_reg_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             active_src_q, active_src_d;
    logic             last_src_q, last_src_d;
    logic             grant0, grant1;
    logic             bit_end;

    // Round-robin grant, offered only while idle; a tie goes to whoever did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && (!req1_valid || last_src_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign bit_end = (baud_cnt_q == CNT_MAX);

    // Frame sequencer: next state, baud counter, shifter and the next tx level.
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_reg_d  = shift_reg_q;
        tx_d         = tx_q;
        done_d       = 1'b0;
        active_src_d = active_src_q;
        last_src_d   = last_src_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (grant0 || grant1) begin
                    shift_reg_d  = grant1 ? req1_data : req0_data;
                    active_src_d = grant1;
                    last_src_d   = grant1;
                    state_d      = START;
                    tx_d         = 1'b0;
                    baud_cnt_d   = '0;
                    bit_idx_d    = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                    tx_d       = shift_reg_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d  = '0;
                    shift_reg_d = shift_reg_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_reg_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; reset drops any frame in flight and parks the line high.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_reg_q  <= '0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
            active_src_q <= 1'b0;
            last_src_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_reg_q  <= shift_reg_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
            active_src_q <= active_src_d;
            last_src_q   <= last_src_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign active_src = active_src_q;
    assign uart_done  = done_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmit serializer between two requesters: req0 is the RISC-V core and req1 is the GEMM accelerator status/debug path.
- Arbitrates round-robin, latches one byte per grant and sequences the frame: start bit, 8 data bits LSB-first, stop bit.
- Generates per-bit timing internally from a clock divider.
- Reports completion with a uart_done pulse, consumed by the software-visible status logic.

Parameters:
- CLKS_PER_BIT, 868, tx_clk cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- DATA_BITS, 8, data bits per frame. Fixed at 8; other values unsupported.

Ports:
- tx_clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a byte.
- req0_data  input  8  requester 0 byte; sampled on acceptance edge only.
- req0_ready  output  1  requester 0 byte accepted this cycle when valid.
- req1_valid  input  1  requester 1 has a byte.
- req1_data  input  8  requester 1 byte.
- req1_ready  output  1  requester 1 accept.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  frame in progress (state != IDLE).
- active_src  output  1  source of the current/last frame (0 = req0, 1 = req1).
- uart_done  output  1  one-cycle pulse, frame fully sent.

Behaviour:
- Reset (async, immediate) values:
  - tx=1, busy=0, uart_done=0, active_src=0.
  - state=IDLE, baud_cnt=0, bit_idx=0, shift_reg=0.
  - last_src=1, so req0 wins the first contention.
- Reset mid-frame:
  - The frame is dropped and tx returns high without completing the frame.
  - No uart_done is produced.
- Ready generation (combinational, asserted only in IDLE):
  - Only one valid: that requester's ready=1.
  - Both valid: grant goes to !last_src; the other ready=0.
  - Outside IDLE: both ready=0.
  - Ready never asserts without the matching valid.
- Acceptance = valid && ready at a rising edge. On that edge:
  - shift_reg <= data, active_src <= granted id, last_src <= granted id.
  - state <= START, tx <= 0, baud_cnt <= 0.
- Requester protocol: a requester holds valid and data stable until ready. Dropping valid before acceptance is permitted and withdraws the request.
- States:
  - IDLE: tx=1; waits for acceptance.
  - START: tx=0 for CLKS_PER_BIT cycles, then goes to DATA with bit_idx=0 and tx=shift_reg[0].
  - DATA: each bit is held CLKS_PER_BIT cycles. At the end of a bit, shift right and increment bit_idx. After bit_idx==7 completes, go to STOP with tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then goes to IDLE with uart_done <= 1.
- baud_cnt:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary.
  - Width is clog2(CLKS_PER_BIT).
- uart_done:
  - Registered; high exactly one cycle, the first IDLE cycle after STOP.
  - Fires 10*CLKS_PER_BIT cycles after the acceptance edge.
- Back-to-back frames:
  - Acceptance is allowed in the same cycle uart_done is high.
  - Minimum spacing between acceptance edges is 10*CLKS_PER_BIT+1 cycles, i.e. one extra idle-high cycle between frames.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Validity of outputs:
  - active_src is valid while busy or uart_done is high, and holds its value in IDLE.
  - tx is glitch-free because it is driven directly from a flop.

Test Plan:
1. CLKS_PER_BIT=4, req0 sends 0xA5, req1 idle.
   - req0_ready=1 in IDLE; acceptance.
   - tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
   - busy high for 40 cycles; uart_done pulses once 40 cycles after acceptance; active_src=0.
2. Both valid after reset (req0=0x11, req1=0x22), held continuously.
   - req0 granted first, then req1.
   - The 0x22 frame's start bit begins 41 cycles after the first acceptance.
   - active_src goes 0 then 1; two uart_done pulses.
3. Both valid continuously for 4 frames.
   - Grant order 0,1,0,1.
   - Ready never asserted while busy.
   - Exactly 4 uart_done pulses, spaced 41 cycles apart.
4. req1 sends 0xFF, then assert reset for 2 cycles in the middle of DATA bit 3.
   - tx=1 immediately on reset; busy=0; no uart_done.
   - After release, req0 (0x00) is granted first (last_src=1) and sends tx 0,0,0,0,0,0,0,0,0,1.
5. req0_valid pulsed for one cycle while a req1 frame is busy.
   - req0_ready stays 0; no acceptance; the in-progress frame is unaffected.
   - tx of the req1 frame is unchanged.
6. CLKS_PER_BIT=2, byte 0x80.
   - tx per 2-cycle bit: 0,0,0,0,0,0,0,0,1,1.
   - uart_done 20 cycles after acceptance.
